motoro3_line_step_sequencer: RTL
================================

// Module: motoro3_line_step_sequencer
// PURPOSE
// - Drives the line-calc parameter path from the other end: generates lcStep / m3LpwmSplitStep and consumes the
//   returned slLen (PWM periods per split-step) and plLen (PWM high clocks) to produce one phase's PWM line.
// - Sits between the motor register file (m3r_*) and the phase driver. Calc logic is combinational on lcStep/split.
// PARAMETERS
// - STEP_NUM   12   lcStep values per electrical cycle (lcStep counts 0..STEP_NUM-1, then wraps)
// - PLEN_W     12   PWM period counter width (matches m3r_pwmLenWant)
// - SLEN_W     16   periods-in-split counter width (matches slLen/plLen)
// PORTS
// - clk               in   1       system clock
// - rst               in   1       synchronous, active-high reset
// - m3r_run           in   1       level: 1 = run sequence, 0 = stop after current period
// - m3r_pwmLenWant    in   12      PWM period length in clocks
// - m3r_stepSplitMax  in   2       last split index per lcStep (0..3)
// - slLen             in   16      from calc: PWM periods per split-step for current lcStep/split
// - plLen             in   16      from calc: PWM high clocks for current lcStep/split
// - lcStep            out  4       current step index to calc
// - m3LpwmSplitStep   out  2       current split index to calc
// - m3_pwmOut         out  1       registered PWM line
// - m3_stepTick       out  1       1-clk pulse when lcStep advances
// - m3_busy           out  1       1 while not IDLE
// BEHAVIOUR
// - Reset (one clk, synchronous, overrides all, any state): state=IDLE; lcStep=0, split=0, counters=0,
//   shadows=0, m3_pwmOut=0, m3_stepTick=0, m3_busy=0.
// - FSM: IDLE -(m3r_run)-> PRELOAD -> RUN -(!m3r_run at last clk of period)-> IDLE.
//   PRELOAD: 1 clk, lcStep=0/split=0 settle through calc; no shadow load.
// - Period counter pcnt: 0..len-1, len = max(m3r_pwmLenWant,2); len sampled at pcnt==0 into shadow.
// - pcnt==0 is the load slot: shadows latch plLen, slLen (0 treated as 1), m3r_stepSplitMax, len.
//   m3_pwmOut is registered; it is 0 during the pcnt==0 slot (fixed 1-clk dead slot per period)
//   and 1 for pcnt in 1..min(pl_sh, len-1); 0 afterwards. plLen=0 -> line stays 0.
// - Output latency: m3_pwmOut reflects the compare of the previous clk (1-clk pipeline), consistently.
// - At pcnt==len-1: period counter ppn (SLEN_W) increments; if ppn==sl_sh-1 -> ppn=0 and split advances.
//   split==max_sh -> split=0 and lcStep advances (STEP_NUM-1 wraps to 0), m3_stepTick=1 next clk.
// - lcStep/split change only on the last clk of a period, so calc outputs settle one clk before
//   the pcnt==0 load. m3r_* changes mid-period have no effect until the next pcnt==0.
// - Shrinking m3r_stepSplitMax below current split: compare is split>=max_sh -> wrap (no runaway).
// - m3r_run low: current period completes (no truncated pulse), then IDLE; lcStep/split hold
//   their values (resume continues position); ppn cleared. m3r_run re-high in IDLE -> PRELOAD,
//   but PRELOAD forces lcStep/split to 0 only after rst; after a stop it keeps held values.
// - m3r_run low and high on the same last clk: run wins, RUN continues uninterrupted.
// - Widths: all compares unsigned; plLen clamp done at PLEN_W+4 bits to avoid truncation.
// STRUCTURE
// - Shared header motoro3_defs.vh: STEP_NUM, FSM state encodings (IDLE/PRELOAD/RUN), PWM_MIN_LEN=2.
// - One sub-module: motoro3_pwm_period_counter (pcnt, len shadow, load-slot, last-clk strobes,
//   compare -> m3_pwmOut). Step/split/ppn logic and FSM stay in this top.
// TESTING
// - rst mid-RUN (lcStep=5) -> next clk all outputs 0, state IDLE, m3_busy=0.
// - len=10, plLen=4, slLen=1, splitMax=0, run=1 -> each 10-clk period: 0 then 1x4 then 0x5;
//   lcStep 0..11 then 0; m3_stepTick every 10 clk.
// - plLen=20 with len=10 -> 9 high clks per period; plLen=0 -> line constant 0.
// - slLen=3, splitMax=2 -> split advances every 30 clk, lcStep every 90 clk; slLen=0 behaves as 1.
// - run dropped at pcnt=3 -> pulse completes, IDLE after pcnt=9; rerun resumes at held lcStep.
// - m3r_pwmLenWant 10->6 at pcnt=5 -> current period stays 10, next period 6; len=1 -> period 2.

Source files
------------

// File: rtl/motoro3_line_step_sequencer_pkg.sv
// motoro3 line-step sequencer: shared sizes, FSM encodings,
// shadow bundle and the lcStep wrap helper.
package motoro3_line_step_sequencer_pkg;

  localparam int STEP_NUM = 12;
  localparam int PLEN_W   = 12;
  localparam int SLEN_W   = 16;
  localparam int STEP_W   = 4;
  localparam int SPLIT_W  = 2;
  localparam int WIDE_W   = PLEN_W + 4;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PRELOAD = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  localparam logic [PLEN_W-1:0] PWM_MIN_LEN = PLEN_W'(2);

  typedef struct packed {
    logic [SLEN_W-1:0]  sl;
    logic [SPLIT_W-1:0] smax;
  } seq_shadow_t;

  function automatic logic [STEP_W-1:0] step_next(
    input logic [STEP_W-1:0] s
  );
    return (s >= STEP_W'(STEP_NUM - 1)) ? '0 : s + STEP_W'(1);
  endfunction

endpackage

// File: rtl/motoro3_line_step_sequencer_pwm_period_counter.sv
// PWM period counter: pcnt, len/plLen shadows, load-slot and
// last-clk strobes, and the registered high/low compare.
module motoro3_line_step_sequencer_pwm_period_counter
  import motoro3_line_step_sequencer_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic [PLEN_W-1:0] len_want_i,
  input  logic [SLEN_W-1:0] pl_len_i,
  output logic              load_o,
  output logic              last_o,
  output logic              pwm_o
);

  logic [PLEN_W-1:0] pcnt_q, pcnt_d;
  logic [PLEN_W-1:0] len_q, len_d;
  logic [PLEN_W-1:0] len_new;
  logic [WIDE_W-1:0] pl_q, pl_d;
  logic [WIDE_W-1:0] pl_max, pl_in;
  logic              pwm_q, pwm_d;

  always_comb begin
    len_new = (len_want_i < PWM_MIN_LEN) ? PWM_MIN_LEN
                                         : len_want_i;
    pl_max  = WIDE_W'(len_new - PLEN_W'(1));
    pl_in   = WIDE_W'(pl_len_i);
    load_o  = en_i && (pcnt_q == '0);
    // len >= 2, so the load slot is never also the last clk
    last_o  = en_i && !load_o &&
              (pcnt_q == len_q - PLEN_W'(1));
    pwm_d   = en_i && !load_o &&
              (WIDE_W'(pcnt_q) <= pl_q);
    pcnt_d  = (!en_i || last_o) ? '0
                                : pcnt_q + PLEN_W'(1);
    len_d   = load_o ? len_new : len_q;
    pl_d    = pl_q;
    if (load_o) begin
      pl_d = (pl_in > pl_max) ? pl_max : pl_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt_q <= '0;
      len_q  <= '0;
      pl_q   <= '0;
      pwm_q  <= 1'b0;
    end else begin
      pcnt_q <= pcnt_d;
      len_q  <= len_d;
      pl_q   <= pl_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_o = pwm_q;

endmodule

// File: rtl/motoro3_line_step_sequencer.sv
// motoro3 line-step sequencer top: run FSM, lcStep/split/ppn
// walk and split shadows around the PWM period counter.
module motoro3_line_step_sequencer
  import motoro3_line_step_sequencer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               m3r_run,
  input  logic [PLEN_W-1:0]  m3r_pwmLenWant,
  input  logic [SPLIT_W-1:0] m3r_stepSplitMax,
  input  logic [SLEN_W-1:0]  slLen,
  input  logic [SLEN_W-1:0]  plLen,
  output logic [STEP_W-1:0]  lcStep,
  output logic [SPLIT_W-1:0] m3LpwmSplitStep,
  output logic               m3_pwmOut,
  output logic               m3_stepTick,
  output logic               m3_busy
);

  logic [1:0]         state_q, state_d;
  logic [STEP_W-1:0]  step_q, step_d;
  logic [SPLIT_W-1:0] split_q, split_d;
  logic [SLEN_W-1:0]  ppn_q, ppn_d;
  seq_shadow_t        sh_q, sh_d;
  logic               tick_q, tick_d;
  logic               run_en, load, last;
  logic               sl_end, sp_end;

  assign run_en = (state_q == ST_RUN);

  motoro3_line_step_sequencer_pwm_period_counter u_pwm (
    .clk        (clk),
    .rst        (rst),
    .en_i       (run_en),
    .len_want_i (m3r_pwmLenWant),
    .pl_len_i   (plLen),
    .load_o     (load),
    .last_o     (last),
    .pwm_o      (m3_pwmOut)
  );

  // >= rather than == keeps a shrunk split max from running away
  assign sl_end = (ppn_q >= sh_q.sl - SLEN_W'(1));
  assign sp_end = (split_q >= sh_q.smax);

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    split_d = split_q;
    ppn_d   = ppn_q;
    sh_d    = sh_q;
    tick_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (m3r_run) state_d = ST_PRELOAD;
      end
      ST_PRELOAD: begin
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (load) begin
          sh_d.sl   = (slLen == '0) ? SLEN_W'(1) : slLen;
          sh_d.smax = m3r_stepSplitMax;
        end
        if (last) begin
          unique case (1'b1)
            !sl_end: begin
              ppn_d = ppn_q + SLEN_W'(1);
            end
            sl_end && !sp_end: begin
              ppn_d   = '0;
              split_d = split_q + SPLIT_W'(1);
            end
            sl_end && sp_end: begin
              ppn_d   = '0;
              split_d = '0;
              step_d  = step_next(step_q);
              tick_d  = 1'b1;
            end
          endcase
          if (!m3r_run) begin
            state_d = ST_IDLE;
            ppn_d   = '0;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      step_q  <= '0;
      split_q <= '0;
      ppn_q   <= '0;
      sh_q    <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      split_q <= split_d;
      ppn_q   <= ppn_d;
      sh_q    <= sh_d;
      tick_q  <= tick_d;
    end
  end

  assign lcStep          = step_q;
  assign m3LpwmSplitStep = split_q;
  assign m3_stepTick     = tick_q;
  assign m3_busy         = (state_q != ST_IDLE);

endmodule
